// File: rtl/mul_div_pkg.sv
// Shared state type, op encodings and default width for the mul/div sequencer.
package mul_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the datapath: shift-add for multiply, subtract/restore
// for divide. acc_hi holds partial product or remainder, acc_lo the shifting operand.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // Top bit of diff set means the trial subtraction borrowed.
    diff = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, operand};
    if (op == OP_MUL) begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      next_hi = diff[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      next_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      next_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative multiply/divide unit driving architectural HI/LO, WIDTH cycles per op.
// Defining MULDIV_SIGNED_EN adds the op_signed port and sign correction.
module mul_div_sequencer
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic             hilo_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             dz_pend_q, dz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_neg;
`endif

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // The iteration always works on magnitudes; signs are reapplied at completion.
  always_comb begin
    a_mag = a;
    b_mag = b;
`ifdef MULDIV_SIGNED_EN
    a_neg = op_signed & a[WIDTH-1];
    b_neg = op_signed & b[WIDTH-1];
    if (a_neg) a_mag = -a;
    if (b_neg) b_mag = -b;
`endif
  end

  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
    prod_neg = -{step_hi, step_lo};
    if (op_q == OP_MUL) begin
      if (res_neg_q) {res_hi, res_lo} = prod_neg;
    end else begin
      if (res_neg_q) res_lo = -step_lo;
      if (rem_neg_q) res_hi = -step_hi;
    end
`endif
    if ((op_q == OP_DIV) && dz_pend_q) res_lo = '1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    dz_pend_d = dz_pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_SIGNED_EN
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
          dz_d    = (op_q == OP_DIV) && dz_pend_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = CW'(WIDTH - 1);
          op_d      = op;
          acc_hi_d  = '0;
          acc_lo_d  = (op == OP_MUL) ? b_mag : a_mag;
          operand_d = (op == OP_MUL) ? a_mag : b_mag;
          dz_pend_d = (op == OP_DIV) && (b == '0);
`ifdef MULDIV_SIGNED_EN
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      dz_pend_q <= dz_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_SIGNED_EN
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign stall       = busy_q & (hilo_read | start);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
